// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: register file, decode, load-use hazard detection and ID/EX register
// Optional macro DECODE_WB_BYPASS_EN: same-cycle writeback data is forwarded to both read ports.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_Instruction,
    input  logic        in_Flush,
    input  logic        in_WB_RegWrite,
    input  logic [2:0]  in_WB_Write_Reg,
    input  logic [15:0] in_WB_Write_Data,
    output logic        O_Stall,
    output logic [15:0] O_Read_Data_1,
    output logic [15:0] O_Read_Data_2,
    output logic [15:0] O_Immediate,
    output logic        O_ALUSrc,
    output logic [1:0]  O_ALUOp,
    output logic        O_RegWrite,
    output logic        O_MemRead,
    output logic        O_MemWrite,
    output logic        O_MemToReg,
    output logic        O_Branch,
    output logic [2:0]  O_Write_Reg,
    output logic [2:0]  O_Rs,
    output logic [2:0]  O_Rt
);
    logic [3:0]  op;
    logic [2:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [15:0] regs [8];
    logic [15:0] rd1, rd2;

    logic        dec_regwrite, dec_alusrc, dec_memread, dec_memwrite, dec_memtoreg, dec_branch;
    logic [1:0]  dec_aluop;
    logic [2:0]  dec_dest;
    logic        uses_rt;
    logic        bubble;

    assign op  = in_Instruction[15:12];
    assign rs  = in_Instruction[11:9];
    assign rt  = in_Instruction[8:6];
    assign rd  = in_Instruction[5:3];
    assign imm = {{10{in_Instruction[5]}}, in_Instruction[5:0]};

    // regs[0] is never written, so it stays zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (in_WB_RegWrite && (in_WB_Write_Reg != 3'd0)) begin
            regs[in_WB_Write_Reg] <= in_WB_Write_Data;
        end
    end

    always_comb begin
        rd1 = (rs == 3'd0) ? 16'd0 : regs[rs];
        rd2 = (rt == 3'd0) ? 16'd0 : regs[rt];
`ifdef DECODE_WB_BYPASS_EN
        if (in_WB_RegWrite && (in_WB_Write_Reg != 3'd0)) begin
            if (in_WB_Write_Reg == rs) rd1 = in_WB_Write_Data;
            if (in_WB_Write_Reg == rt) rd2 = in_WB_Write_Data;
        end
`endif
    end

    always_comb begin
        dec_regwrite = 1'b0;
        dec_alusrc   = 1'b0;
        dec_aluop    = 2'b00;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_memtoreg = 1'b0;
        dec_branch   = 1'b0;
        dec_dest     = 3'd0;
        uses_rt      = 1'b0;
        case (op)
            4'b0000: begin
                dec_regwrite = 1'b1;
                dec_aluop    = 2'b10;
                dec_dest     = rd;
                uses_rt      = 1'b1;
            end
            4'b0100: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_memread  = 1'b1;
                dec_memtoreg = 1'b1;
                dec_dest     = rt;
            end
            4'b0101: begin
                dec_alusrc   = 1'b1;
                dec_memwrite = 1'b1;
                uses_rt      = 1'b1;
            end
            4'b0110: begin
                dec_aluop    = 2'b01;
                dec_branch   = 1'b1;
                uses_rt      = 1'b1;
            end
            4'b0111: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_dest     = rt;
            end
            default: ;
        endcase
    end

    // Load in EX whose result feeds this instruction: hold upstream and insert one bubble.
    assign O_Stall = O_MemRead && (O_Write_Reg != 3'd0) &&
                     ((O_Write_Reg == rs) || ((O_Write_Reg == rt) && uses_rt));
    assign bubble  = in_Flush || O_Stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble) begin
            O_Read_Data_1 <= '0;
            O_Read_Data_2 <= '0;
            O_Immediate   <= '0;
            O_ALUSrc      <= 1'b0;
            O_ALUOp       <= 2'b00;
            O_RegWrite    <= 1'b0;
            O_MemRead     <= 1'b0;
            O_MemWrite    <= 1'b0;
            O_MemToReg    <= 1'b0;
            O_Branch      <= 1'b0;
            O_Write_Reg   <= 3'd0;
            O_Rs          <= 3'd0;
            O_Rt          <= 3'd0;
        end else begin
            O_Read_Data_1 <= rd1;
            O_Read_Data_2 <= rd2;
            O_Immediate   <= imm;
            O_ALUSrc      <= dec_alusrc;
            O_ALUOp       <= dec_aluop;
            O_RegWrite    <= dec_regwrite;
            O_MemRead     <= dec_memread;
            O_MemWrite    <= dec_memwrite;
            O_MemToReg    <= dec_memtoreg;
            O_Branch      <= dec_branch;
            O_Write_Reg   <= dec_dest;
            O_Rs          <= rs;
            O_Rt          <= rt;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized bench for decode_stage against a behavioural model
`timescale 1ns/1ps
module tb_decode_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] instr;
    logic        flush, we;
    logic [2:0]  wr;
    logic [15:0] wd;

    logic        O_Stall;
    logic [15:0] O_Read_Data_1, O_Read_Data_2, O_Immediate;
    logic        O_ALUSrc;
    logic [1:0]  O_ALUOp;
    logic        O_RegWrite, O_MemRead, O_MemWrite, O_MemToReg, O_Branch;
    logic [2:0]  O_Write_Reg, O_Rs, O_Rt;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_Instruction(instr), .in_Flush(flush),
        .in_WB_RegWrite(we), .in_WB_Write_Reg(wr), .in_WB_Write_Data(wd),
        .O_Stall(O_Stall), .O_Read_Data_1(O_Read_Data_1), .O_Read_Data_2(O_Read_Data_2),
        .O_Immediate(O_Immediate), .O_ALUSrc(O_ALUSrc), .O_ALUOp(O_ALUOp),
        .O_RegWrite(O_RegWrite), .O_MemRead(O_MemRead), .O_MemWrite(O_MemWrite),
        .O_MemToReg(O_MemToReg), .O_Branch(O_Branch), .O_Write_Reg(O_Write_Reg),
        .O_Rs(O_Rs), .O_Rt(O_Rt)
    );

    typedef struct packed {
        logic [15:0] rd1, rd2, imm;
        logic        alusrc;
        logic [1:0]  aluop;
        logic        regwrite, memread, memwrite, memtoreg, branch;
        logic [2:0]  wreg, rs, rt;
    } idex_t;

    idex_t       exp_q, act;
    logic [15:0] mregs [8];
    logic        m_stall;
    int          checks = 0;
    int          errors = 0;

    assign act = {O_Read_Data_1, O_Read_Data_2, O_Immediate, O_ALUSrc, O_ALUOp, O_RegWrite,
                  O_MemRead, O_MemWrite, O_MemToReg, O_Branch, O_Write_Reg, O_Rs, O_Rt};

    function automatic logic reads_rt(input logic [3:0] op);
        return (op == 4'h0) || (op == 4'h5) || (op == 4'h6);
    endfunction

    function automatic logic [15:0] mread(input logic [2:0] n);
        if (n == 3'd0) return 16'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (we && wr == n) return wd;
`endif
        return mregs[n];
    endfunction

    always_comb m_stall = exp_q.memread && (exp_q.wreg != 3'd0) &&
                          ((exp_q.wreg == instr[11:9]) || ((exp_q.wreg == instr[8:6]) && reads_rt(instr[15:12])));

    always @(posedge clk or posedge rst) begin
        idex_t n;
        if (rst) begin
            exp_q <= '0;
            for (int i = 0; i < 8; i++) mregs[i] <= '0;
        end else begin
            n = '0;
            if (!(flush || m_stall)) begin
                n.rs  = instr[11:9];
                n.rt  = instr[8:6];
                n.rd1 = mread(n.rs);
                n.rd2 = mread(n.rt);
                n.imm = 16'($signed(instr[5:0]));
                case (instr[15:12])
                    4'h0: begin {n.regwrite, n.alusrc, n.aluop, n.memread, n.memwrite, n.memtoreg, n.branch} = 8'b1_0_10_0_0_0_0; n.wreg = instr[5:3]; end
                    4'h4: begin {n.regwrite, n.alusrc, n.aluop, n.memread, n.memwrite, n.memtoreg, n.branch} = 8'b1_1_00_1_0_1_0; n.wreg = instr[8:6]; end
                    4'h5: {n.regwrite, n.alusrc, n.aluop, n.memread, n.memwrite, n.memtoreg, n.branch} = 8'b0_1_00_0_1_0_0;
                    4'h6: {n.regwrite, n.alusrc, n.aluop, n.memread, n.memwrite, n.memtoreg, n.branch} = 8'b0_0_01_0_0_0_1;
                    4'h7: begin {n.regwrite, n.alusrc, n.aluop, n.memread, n.memwrite, n.memtoreg, n.branch} = 8'b1_1_00_0_0_0_0; n.wreg = instr[8:6]; end
                    default: ;
                endcase
            end
            exp_q <= n;
            if (we && wr != 3'd0) mregs[wr] <= wd;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (act !== exp_q) begin
            errors++;
            $display("FAIL idex_regs instr=%h actual=%h required=%h", instr, act, exp_q);
        end
        checks++;
        if (O_Stall !== m_stall) begin
            errors++;
            $display("FAIL stall instr=%h actual=%b required=%b", instr, O_Stall, m_stall);
        end
    end

    task automatic chk(input string name, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; instr = 16'h0; flush = 1'b0; we = 1'b0; wr = 3'd0; wd = 16'h0;
        tick(); tick();
        chk("reset_stall", 16'(O_Stall), 16'h0);
        chk("reset_regwrite", 16'(O_RegWrite), 16'h0);
        chk("reset_rd1", O_Read_Data_1, 16'h0);
        chk("reset_wreg", 16'(O_Write_Reg), 16'h0);
        rst = 1'b0;

        instr = 16'h707D; tick();
        chk("addi_imm", O_Immediate, 16'hFFFD);
        chk("addi_alusrc", 16'(O_ALUSrc), 16'h1);
        chk("addi_aluop", 16'(O_ALUOp), 16'h0);
        chk("addi_regwrite", 16'(O_RegWrite), 16'h1);
        chk("addi_wreg", 16'(O_Write_Reg), 16'h1);

        instr = 16'hF000; we = 1'b1; wr = 3'd2; wd = 16'h1234; tick();
        we = 1'b0; instr = 16'h0498; tick();
        chk("rtype_rd1", O_Read_Data_1, 16'h1234);
        chk("rtype_rd2", O_Read_Data_2, 16'h1234);
        chk("rtype_wreg", 16'(O_Write_Reg), 16'h3);
        chk("rtype_aluop", 16'(O_ALUOp), 16'h2);

        instr = 16'h4100; tick();
        chk("lw_memread", 16'(O_MemRead), 16'h1);
        instr = 16'h0868; #1;
        chk("loaduse_stall", 16'(O_Stall), 16'h1);
        tick();
        chk("bubble_regwrite", 16'(O_RegWrite), 16'h0);
        chk("bubble_wreg", 16'(O_Write_Reg), 16'h0);
        chk("stall_released", 16'(O_Stall), 16'h0);
        tick();
        chk("after_stall_wreg", 16'(O_Write_Reg), 16'h5);
        chk("after_stall_regwrite", 16'(O_RegWrite), 16'h1);

        instr = 16'h4100; tick();
        instr = 16'h7301; #1;
        chk("lw_addi_nostall", 16'(O_Stall), 16'h0);
        tick();
        chk("lw_addi_wreg", 16'(O_Write_Reg), 16'h4);

        instr = 16'hF000; we = 1'b1; wr = 3'd5; wd = 16'h1111; tick();
        instr = 16'h0A08; wd = 16'hBEEF; tick();
        we = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
        chk("same_cycle_wb", O_Read_Data_1, 16'hBEEF);
`else
        chk("same_cycle_wb", O_Read_Data_1, 16'h1111);
`endif
        tick();
        chk("next_cycle_wb", O_Read_Data_1, 16'hBEEF);

        instr = 16'h0000; we = 1'b1; wr = 3'd0; wd = 16'hFFFF; tick();
        we = 1'b0;
        chk("r0_same_cycle", O_Read_Data_1, 16'h0);
        tick();
        chk("r0_after", O_Read_Data_1, 16'h0);

        instr = 16'h4100; flush = 1'b1; tick();
        flush = 1'b0;
        chk("flush_memread", 16'(O_MemRead), 16'h0);
        chk("flush_regwrite", 16'(O_RegWrite), 16'h0);

        instr = 16'h707D; tick();
        #1 rst = 1'b1;
        #1;
        chk("midrst_imm", O_Immediate, 16'h0);
        chk("midrst_regwrite", 16'(O_RegWrite), 16'h0);
        tick();
        rst = 1'b0;

        for (int c = 0; c < 2000; c++) begin
            logic [3:0] op;
            rst = ($urandom_range(0, 99) == 0);
            if (!m_stall) begin
                case ($urandom_range(0, 5))
                    0: op = 4'h0;
                    1: op = 4'h4;
                    2: op = 4'h5;
                    3: op = 4'h6;
                    4: op = 4'h7;
                    default: op = 4'($urandom);
                endcase
                instr = {op, 12'($urandom)};
            end
            flush = ($urandom_range(0, 9) == 0);
            we    = 1'($urandom);
            wr    = 3'($urandom);
            wd    = 16'($urandom);
            tick();
        end
        rst = 1'b0; flush = 1'b0; we = 1'b0;
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
